// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus bundle: prefetch port, data port and external memory port.
// master = arbiter side, slave = requesters plus memory side.
interface mem_arbiter_if;
  logic        i_access;
  logic        i_ack;
  logic [19:0] i_address;
  logic [15:0] i_data;
  logic        d_access;
  logic        d_ack;
  logic [19:0] d_address;
  logic        d_wr_en;
  logic [15:0] d_wr_data;
  logic [1:0]  d_bytesel;
  logic        d_lock;
  logic [15:0] d_data;
  logic        m_access;
  logic        m_ack;
  logic [19:0] m_address;
  logic        m_wr_en;
  logic [15:0] m_wr_data;
  logic [1:0]  m_bytesel;
  logic [15:0] m_data;

  modport master (
    input  i_access, i_address,
    output i_ack, i_data,
    input  d_access, d_address, d_wr_en,
    input  d_wr_data, d_bytesel, d_lock,
    output d_ack, d_data,
    output m_access, m_address, m_wr_en,
    output m_wr_data, m_bytesel,
    input  m_ack, m_data
  );

  modport slave (
    output i_access, i_address,
    input  i_ack, i_data,
    output d_access, d_address, d_wr_en,
    output d_wr_data, d_bytesel, d_lock,
    input  d_ack, d_data,
    input  m_access, m_address, m_wr_en,
    input  m_wr_data, m_bytesel,
    output m_ack, m_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Prefetch/data arbiter for the 16-bit memory port, data-priority with run limit.
// Define MEM_ARB_STATS_EN to add the i_stall_cycles counter output.
module mem_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] i_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_e;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  state_e      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic        m_access;
  logic [19:0] m_address;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic        i_ack;
  logic        d_ack;

  always_comb begin
    state_d   = state_q;
    m_access  = 1'b0;
    m_address = '0;
    m_wr_en   = 1'b0;
    m_bytesel = 2'b11;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_access &&
            (run_q < RUN_MAX || !bus.i_access))
          state_d = GNT_D;
        else if (bus.i_access)
          state_d = GNT_I;
      end
      GNT_I: begin
        m_access  = bus.i_access;
        m_address = bus.i_address;
        i_ack     = bus.m_ack;
        if (!bus.i_access || bus.m_ack)
          state_d = IDLE;
      end
      GNT_D: begin
        m_access  = bus.d_access;
        m_address = bus.d_address;
        m_wr_en   = bus.d_wr_en;
        m_bytesel = bus.d_bytesel;
        d_ack     = bus.m_ack;
        // a locked completion keeps the grant for the next access
        if (!bus.d_access)
          state_d = IDLE;
        else if (bus.m_ack && !bus.d_lock)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d = run_q;
    if (!bus.i_access || i_ack)
      run_d = '0;
    else if (d_ack && run_q < RUN_MAX)
      run_d = run_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign bus.m_access  = m_access;
  assign bus.m_address = m_address;
  assign bus.m_wr_en   = m_wr_en;
  assign bus.m_bytesel = m_bytesel;
  assign bus.m_wr_data = bus.d_wr_data;
  assign bus.i_ack     = i_ack;
  assign bus.d_ack     = d_ack;
  assign bus.i_data    = bus.m_data;
  assign bus.d_data    = bus.m_data;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.i_access && state_q != GNT_I &&
        stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_q <= '0;
    else
      stall_q <= stall_d;
  end

  assign i_stall_cycles = stall_q;
`endif

endmodule
